// File: rtl/vpu_pkg.sv
// +--------------------------------------------------------------------------+
// | vpu_pkg : shared fetch-sequencer states and opcode constants             |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package vpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_DONE  = 3'd4
  } fetch_state_t;

  localparam int          OPC_MSB  = 31;
  localparam int          OPC_LSB  = 28;
  localparam logic [3:0]  OPC_HALT = 4'hF;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_seq.sv
// +--------------------------------------------------------------------------+
// | instr_fetch_seq : PC walker feeding the VPU decoder over valid/ready     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fetch_seq
  import vpu_pkg::*;
#(
  parameter  int INSTR_WIDTH = 32,
  parameter  int DEPTH       = 256,
  parameter  int CNT_WIDTH   = 16,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      start_addr,
  input  logic                   load_busy,
  input  logic                   halt_req,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [INSTR_WIDTH-1:0] rd_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_addr,
  output logic [ADDR_W-1:0]      pc,
  output logic                   running,
  output logic                   done,
  output logic                   err_overflow,
  output logic                   err_abort,
  output logic [CNT_WIDTH-1:0]   retired
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fetch_state_t           state, state_nxt;
  logic [ADDR_W-1:0]      pc_nxt;
  logic [INSTR_WIDTH-1:0] instr_nxt;
  logic                   ovf_nxt, abort_nxt;
  logic [CNT_WIDTH-1:0]   ret_nxt;
  logic                   is_halt;

  assign is_halt     = (instr[OPC_MSB:OPC_LSB] == OPC_HALT);
  assign rd_addr     = pc;
  assign instr_valid = (state == S_VALID);
  assign running     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_VALID);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= '0;
      instr        <= '0;
      err_overflow <= 1'b0;
      err_abort    <= 1'b0;
      retired      <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      instr        <= instr_nxt;
      err_overflow <= ovf_nxt;
      err_abort    <= abort_nxt;
      retired      <= ret_nxt;
    end
  end

  // Abort beats halt beats redirect beats increment; abort also kills a pending handshake.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    ovf_nxt   = err_overflow;
    abort_nxt = err_abort;
    ret_nxt   = retired;
    case (state)
      S_IDLE, S_DONE: begin
        if (start && !load_busy) begin
          state_nxt = S_ISSUE;
          pc_nxt    = start_addr;
          ret_nxt   = '0;
          ovf_nxt   = 1'b0;
          abort_nxt = 1'b0;
        end
      end
      S_ISSUE: begin
        if (load_busy) begin
          state_nxt = S_DONE;
          abort_nxt = 1'b1;
        end else if (halt_req) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (load_busy) begin
          state_nxt = S_DONE;
          abort_nxt = 1'b1;
        end else if (halt_req) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_VALID;
          instr_nxt = rd_data;
        end
      end
      S_VALID: begin
        if (load_busy) begin
          state_nxt = S_DONE;
          abort_nxt = 1'b1;
        end else if (instr_ready) begin
          if (retired != '1) ret_nxt = retired + CNT_WIDTH'(1);
          if (is_halt || halt_req) begin
            state_nxt = S_DONE;
          end else if (redirect_valid) begin
            state_nxt = S_ISSUE;
            pc_nxt    = redirect_addr;
          end else if (pc == LAST_ADDR) begin
            state_nxt = S_DONE;
            ovf_nxt   = 1'b1;
          end else begin
            state_nxt = S_ISSUE;
            pc_nxt    = pc + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Instruction fetch sequencer for the vector processing unit. It owns the read port of the UART-loaded instruction memory (`rd_addr`/`rd_data`) and walks a program counter through it. Fetched words go to the decode/execute FSM over a valid/ready handshake, and the sequencer applies consumer-driven redirects (branch/jump) and stops on a HALT opcode. It sits between the instruction memory loader and the VPU control FSM, and refuses to run while the loader is writing.

## Interface
- `INSTR_WIDTH`, 32, instruction word width
- `DEPTH`, 256, instruction memory depth in words; `ADDR_W = $clog2(DEPTH)`
- `CNT_WIDTH`, 16, width of retired-instruction counter
- `clk`  in  1  system clock (CLOCK_50 domain)
- `rst_n`  in  1  asynchronous, active-low reset; one clock domain only
- `start`  in  1  single-cycle pulse, begin execution at `start_addr`
- `start_addr`  in  ADDR_W  first PC
- `load_busy`  in  1  loader is writing memory
- `halt_req`  in  1  external stop request (level)
- `rd_addr`  out  ADDR_W  memory read address (= `pc`)
- `rd_data`  in  INSTR_WIDTH  memory read data, valid one cycle after `rd_addr`
- `instr`  out  INSTR_WIDTH  registered fetched instruction
- `instr_valid`  out  1  `instr` is offered
- `instr_ready`  in  1  consumer accepts
- `redirect_valid`  in  1  sampled only on handshake cycle
- `redirect_addr`  in  ADDR_W  next PC when redirecting
- `pc`  out  ADDR_W  current program counter
- `running`  out  1  FSM in ISSUE/WAIT/VALID
- `done`  out  1  FSM in DONE
- `err_overflow`  out  1  sticky, fell off end of memory
- `err_abort`  out  1  sticky, loader became busy mid-run
- `retired`  out  CNT_WIDTH  accepted-instruction count, saturating

## Operation
- States: IDLE, ISSUE, WAIT, VALID, DONE.
- IDLE/DONE: `start & ~load_busy` → `pc<=start_addr`, clear `retired`, `err_*`; go ISSUE. If `load_busy` is high, `start` is ignored.
- ISSUE: `rd_addr=pc` presented → WAIT.
- WAIT: `instr<=rd_data` at end of cycle → VALID.
- VALID: `instr_valid=1`. `instr` and `pc` hold until `instr_valid & instr_ready`. On handshake:
  - `retired` increments, saturating at all-ones.
  - If `instr[OPC_MSB:OPC_LSB]==OPC_HALT`, or `halt_req` is high → DONE.
  - Otherwise, if `redirect_valid` → `pc<=redirect_addr` → ISSUE.
  - Otherwise, if `pc==DEPTH-1` → DONE, set `err_overflow`.
  - Otherwise `pc<=pc+1` → ISSUE.
- `halt_req` in ISSUE/WAIT → DONE next cycle; no instruction offered. In VALID, `instr_valid` is never withdrawn without a handshake; the halt takes effect at the handshake.
- `load_busy` high in ISSUE/WAIT/VALID → DONE next cycle, set `err_abort`. This overrides the handshake, and `instr_valid` drops. Abort takes priority over halt, which takes priority over redirect, which takes priority over increment.
- `start` while running is ignored.

## Timing
- Reset values: state IDLE, `pc=0`, `rd_addr=0`, `instr=0`, `instr_valid=0`, `running=0`, `done=0`, `err_*=0`, `retired=0`.
- All outputs are registered or decoded from registered state; there is no combinational path from `instr_ready` to any output.
- `start` in cycle N: ISSUE in N+1, WAIT in N+2, `instr_valid` in N+3.
- Steady state, with `instr_ready` held high: one instruction every 3 cycles.
- Redirect costs nothing extra: the target is offered 3 cycles after the handshake.
- `done` rises the cycle after the terminating handshake, halt, or abort.
- Reset asserted mid-run returns the FSM to IDLE immediately (asynchronously).

## Structure
- Shared package `vpu_pkg`:
  - `fetch_state_t` enum
  - `OPC_MSB=31`, `OPC_LSB=28`, `OPC_HALT=4'hF`
- Single module. No sub-module: the counter and FSM are small.
- The top level maps `done`/`err_*` to LEDR and `pc` to HEX0/HEX1.

## Test plan
- Memory at 0..2 = 0x1000_0001, 0x1000_0002, 0xF000_0000; `start` at addr 0 with `instr_ready=1` → valids at +3, +6, +9; `done` asserts; `retired=3`; `pc=2`.
- `instr_ready` held low 5 cycles at the first VALID → `instr`/`pc` stable; exactly one accept.
- `redirect_valid=1`, `redirect_addr=0x40` on the first handshake → next `rd_addr=0x40`; the fetch at 0x40 is offered 3 cycles later.
- `start_addr=0xFF`, non-HALT word at 0xFF, accepted → DONE, `err_overflow=1`, `pc=0xFF`.
- `load_busy` pulse in WAIT → DONE next cycle, `err_abort=1`, no `instr_valid`. `start` with `load_busy=1` → stays in IDLE.
- `rst_n` low in VALID → all outputs at reset values within the same cycle.
